// File: rtl/mseq_pkg.sv
// Shared types and opcode classes for the matrix op sequencer.
package mseq_pkg;

  localparam int N_ELEM    = 25;
  localparam int ELEM_W    = 8;
  localparam int DET_BYTES = 2;
  localparam int MAT_W     = N_ELEM * ELEM_W;

  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_MUL    = 4'b0101;
  localparam logic [3:0] OP_TRN    = 4'b0110;
  localparam logic [3:0] OP_NEG    = 4'b0111;
  localparam logic [3:0] OP_SCL    = 4'b1000;
  localparam logic [3:0] OP_DET_LO = 4'b1001;
  localparam logic [3:0] OP_DET_HI = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_STORE,
    S_RESP
  } state_t;

  function automatic logic is_binary(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL};
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return op inside {OP_TRN, OP_NEG, OP_SCL};
  endfunction

  function automatic logic is_det(input logic [3:0] op);
    return (op >= OP_DET_LO) && (op <= OP_DET_HI);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_binary(op) || is_unary(op) || is_det(op);
  endfunction

endpackage

// File: rtl/mseq_elem_loader.sv
// Byte-serial matrix fetch: index/address generator plus read-capture stage.
module mseq_elem_loader
  import mseq_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              sel,
  input  logic [ADDR_W-1:0] base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [ELEM_W-1:0] rdata,
  output logic              done,
  output logic [MAT_W-1:0]  mat_a,
  output logic [MAT_W-1:0]  mat_b
);

  localparam int IW = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);

  logic [IW-1:0] idx;
  logic [IW-1:0] cap_idx;
  logic          cap_vld;

  assign done = cap_vld && (cap_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      addr    <= '0;
      idx     <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      mat_a   <= '0;
      mat_b   <= '0;
    end else begin
      cap_vld <= rd_en;
      cap_idx <= idx;
      if (start) begin
        rd_en <= 1'b1;
        addr  <= base;
        idx   <= '0;
      end else if (rd_en) begin
        rd_en <= (idx != LAST);
        addr  <= addr + ADDR_W'(1);
        idx   <= idx + IW'(1);
      end
      // data for the read issued last cycle lands here
      if (clr) begin
        mat_a <= '0;
        mat_b <= '0;
      end else if (cap_vld) begin
        if (sel)
          mat_b[int'(cap_idx)*ELEM_W +: ELEM_W] <= rdata;
        else
          mat_a[int'(cap_idx)*ELEM_W +: ELEM_W] <= rdata;
      end
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command sequencer for the 5x5 int8 matrix ALU (fetch, exec, store, respond).
// Optional EXEC watchdog: define MSEQ_TIMEOUT_EN.
module matrix_op_sequencer
  import mseq_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [7:0]        cmd_scalar,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_scalar,
  output logic [MAT_W-1:0]  alu_mat_a,
  output logic [MAT_W-1:0]  alu_mat_b,
  input  logic [MAT_W-1:0]  alu_result,
  input  logic              alu_done
);

  localparam int IW = $clog2(N_ELEM);

  state_t            state, state_n;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_b_q, addr_c_q, wr_addr, ld_addr;
  logic [MAT_W-1:0]  res_q;
  logic [IW-1:0]     widx;
  logic              wr_en, wr_last;
  logic [7:0]        wdata;
  logic              accept, ld_start, ld_done, ld_rd;
  logic              err_n, tmo;

  assign accept  = (state == S_IDLE) && cmd_valid;
  assign wr_last = wr_en && (widx == (is_det(op_q) ?
                   IW'(DET_BYTES - 1) : IW'(N_ELEM - 1)));

  assign mem_rd_en = ld_rd;
  assign mem_wr_en = wr_en;
  assign mem_wdata = wdata;
  assign mem_addr  = ld_rd ? ld_addr : (wr_en ? wr_addr : '0);

  mseq_elem_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .start (ld_start),
    .sel   (state == S_LOAD_B),
    .base  ((state == S_IDLE) ? cmd_addr_a : addr_b_q),
    .rd_en (ld_rd),
    .addr  (ld_addr),
    .rdata (mem_rdata),
    .done  (ld_done),
    .mat_a (alu_mat_a),
    .mat_b (alu_mat_b)
  );

`ifdef MSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= '0;
    else if (state != S_EXEC)
      tcnt <= '0;
    else
      tcnt <= tcnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    ld_start = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        if (is_legal(cmd_opcode)) begin
          state_n  = S_LOAD_A;
          ld_start = 1'b1;
        end else begin
          state_n = S_RESP;
          err_n   = 1'b1;
        end
      end
      S_LOAD_A: if (ld_done) begin
        if (is_binary(op_q)) begin
          state_n  = S_LOAD_B;
          ld_start = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_LOAD_B: if (ld_done) state_n = S_EXEC;
      S_EXEC: begin
        if (alu_done) begin
          state_n = S_STORE;
        end else if (tmo) begin
          state_n = S_RESP;
          err_n   = 1'b1;
        end
      end
      S_STORE: if (wr_last) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      alu_opcode <= '0;
      alu_scalar <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wdata      <= '0;
      widx       <= '0;
      res_q      <= '0;
    end else begin
      state      <= state_n;
      cmd_ready  <= (state_n == S_IDLE);
      rsp_valid  <= (state_n == S_RESP);
      rsp_err    <= err_n;
      alu_opcode <= (state_n == S_EXEC) ? op_q : 4'b0000;
      if (accept) begin
        op_q       <= cmd_opcode;
        alu_scalar <= cmd_scalar;
        addr_b_q   <= cmd_addr_b;
        addr_c_q   <= cmd_addr_c;
      end
      // result drains low byte first through a shift register
      if ((state == S_EXEC) && alu_done) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_c_q;
        wdata   <= alu_result[ELEM_W-1:0];
        res_q   <= alu_result >> ELEM_W;
        widx    <= '0;
      end else if (wr_en) begin
        wr_en   <= !wr_last;
        wr_addr <= wr_addr + ADDR_W'(1);
        wdata   <= res_q[ELEM_W-1:0];
        res_q   <= res_q >> ELEM_W;
        widx    <= widx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with behavioural memory and ALU.
module tb_matrix_op_sequencer;

  localparam int AW = 8;
`ifdef MSEQ_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [7:0]    cmd_scalar;
  logic [AW-1:0] cmd_addr_a, cmd_addr_b, cmd_addr_c;
  logic          rsp_valid, rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [7:0]    mem_rdata, mem_wdata;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_scalar;
  logic [199:0]  alu_mat_a, alu_mat_b, alu_result;
  logic          alu_done;

  always #5 clk = ~clk;

  matrix_op_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_scalar (cmd_scalar),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_addr_c (cmd_addr_c),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .alu_opcode (alu_opcode),
    .alu_scalar (alu_scalar),
    .alu_mat_a  (alu_mat_a),
    .alu_mat_b  (alu_mat_b),
    .alu_result (alu_result),
    .alu_done   (alu_done)
  );

  logic [7:0] mem [256];
  logic [7:0] rd_log [64];
  int n_rd = 0, n_wr = 0, n_both = 0, n_rd_b = 0;
  int n_cmp = 0, n_bad = 0;
  logic alu_hold = 1'b0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      if (n_rd < 64) rd_log[n_rd] = mem_addr;
      n_rd++;
      if (mem_addr >= 8'h20 && mem_addr <= 8'h38) n_rd_b++;
    end
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      n_wr++;
    end
    if (mem_rd_en && mem_wr_en) n_both++;
  end

  function automatic logic [199:0] alu_model(input logic [3:0] op,
                                             input logic [199:0] a,
                                             input logic [199:0] b);
    logic [199:0] r = '0;
    for (int k = 0; k < 25; k++) begin
      case (op)
        4'b0011: r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
        4'b0110: r[8*k +: 8] = a[8*((k % 5) * 5 + k / 5) +: 8];
        4'b0111: r[8*k +: 8] = 8'h00 - a[8*k +: 8];
        default: r[8*k +: 8] = 8'hAA;
      endcase
    end
    if (op >= 4'd9 && op <= 4'd12) r[15:0] = 16'hFFFE;
    return r;
  endfunction

  always @(posedge clk) begin
    alu_done   <= (alu_opcode != 4'b0000) && !alu_hold;
    alu_result <= alu_model(alu_opcode, alu_mat_a, alu_mat_b);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    cmd_opcode = op;
    cmd_scalar = 8'h03;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_addr_c = c;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // returns n where rsp_valid was seen in cycle Tn, 0 if never
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c,
                         output int tr);
    issue(op, a, b, c);
    tr = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        tr = n;
        break;
      end
    end
    if (tr == 0) chk("rsp_seen", 0, 1);
  endtask

  initial begin
    int tr;
    int seen;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_scalar = '0;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_addr_c = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h55;
    for (int k = 0; k < 25; k++) begin
      mem[k]        = 8'(k);
      mem[8'h20 + k] = 8'h01;
      mem[8'h60 + k] = 8'h00;
    end
    for (int c = 0; c < 5; c++) mem[8'h60 + c] = 8'(c + 1);
    for (int i = 1; i < 5; i++) mem[8'h60 + 6 * i] = 8'h01;

    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_mem", {mem_rd_en, mem_wr_en}, 0);
    chk("rst_op", alu_opcode, 0);
    chk("rst_mat", (alu_mat_a == '0 && alu_mat_b == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // add: A=k, B=1
    run_cmd(4'b0011, 8'h00, 8'h20, 8'h40, tr);
    chk("add_rsp_t", tr, 80);
    chk("add_err", rsp_err, 0);
    @(negedge clk);
    chk("add_ready", cmd_ready, 1);
    for (int k = 0; k < 25; k++)
      chk($sformatf("add_c%0d", k), mem[8'h40 + k], k + 1);

    // transpose: must not touch B
    n_rd_b = 0;
    run_cmd(4'b0110, 8'h60, 8'h20, 8'h80, tr);
    chk("trn_rsp_t", tr, 54);
    chk("trn_b_reads", n_rd_b, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("trn_c%0d", 5 * i), mem[8'h80 + 5 * i], i + 1);

    // determinant: two little-endian bytes only
    n_wr = 0;
    run_cmd(4'b1001, 8'h00, 8'h20, 8'hA0, tr);
    chk("det_rsp_t", tr, 31);
    chk("det_writes", n_wr, 2);
    chk("det_b0", mem[8'hA0], 8'hFE);
    chk("det_b1", mem[8'hA1], 8'hFF);
    chk("det_b2", mem[8'hA2], 8'h55);

    // illegal opcode
    n_rd = 0;
    n_wr = 0;
    run_cmd(4'b1111, 8'h00, 8'h20, 8'hA0, tr);
    chk("ill_rsp_t", tr, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_strobes", n_rd + n_wr, 0);
    @(negedge clk);
    chk("ill_ready", cmd_ready, 1);

    // address wrap then reset mid-STORE
    n_rd = 0;
    n_wr = 0;
    issue(4'b0111, 8'hF0, 8'h20, 8'hC0);
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        seen = 1;
        break;
      end
    end
    chk("wrap_store_seen", seen, 1);
    chk("wrap_nrd", n_rd, 25);
    chk("wrap_rd0", rd_log[0], 8'hF0);
    chk("wrap_rd15", rd_log[15], 8'hFF);
    chk("wrap_rd16", rd_log[16], 8'h00);
    chk("wrap_rd24", rd_log[24], 8'h08);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", mem_wr_en, 0);
    chk("rst_ready_async", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_no_write", n_wr, 0);

`ifdef MSEQ_TIMEOUT_EN
    alu_hold = 1'b1;
    n_wr = 0;
    run_cmd(4'b0110, 8'h60, 8'h20, 8'hC0, tr);
    chk("tmo_rsp_t", tr, 37);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_op", alu_opcode, 0);
    chk("tmo_writes", n_wr, 0);
    alu_hold = 1'b0;
`endif

    chk("rd_wr_overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
